// File: rtl/mem_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl_if
// Bundles every non-clock/reset signal of mem_req_ctrl: the request channel,
// the response channel, the clear pulse, the busy flag and the raw pins of the
// 4-bank x 1024 x 8 memory.
//
// Signals
//   req_valid/req_ready/req_wr/req_addr[11:0]/req_wdata[7:0] : request channel
//   clr_req                                                  : clear-memory pulse
//   rsp_valid/rsp_ready/rsp_rdata[7:0]/rsp_addr[11:0]        : read response
//   busy                                                     : controller activity
//   mem_cen/mem_rd/mem_wr/mem_rst/mem_add[11:0]/mem_din[7:0] : memory pins (out)
//   mem_dout[7:0]                                            : memory read data (in)
//
// Modports
//   slave  : the controller itself
//   master : requester, response consumer and memory model (testbench side)
// ---------------------------------------------------------------------------
interface mem_req_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        clr_req;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic [11:0] rsp_addr;
  logic        busy;
  logic        mem_cen;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_rst;
  logic [11:0] mem_add;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, clr_req, rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_addr, busy,
           mem_cen, mem_rd, mem_wr, mem_rst, mem_add, mem_din
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, clr_req, rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_addr, busy,
           mem_cen, mem_rd, mem_wr, mem_rst, mem_add, mem_din
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
// Request-side sequencer in front of a 4-bank x 1024 x 8 synchronous memory.
// Requests are queued in a small FIFO and issued one at a time with the
// memory's pin timing; read data is returned on a valid/ready response
// channel; a clear pulse is remembered until the memory's clear is sequenced.
//
// Ports
//   clk  : clock, all logic on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_req_ctrl_if.slave (request, response, clear, busy, memory pins)
//
// Parameters
//   FIFO_DEPTH : request FIFO entries (power of 2, >= 2)
//   WR_CYC     : cycles mem_wr/mem_cen are held for one write
//   RD_LAT     : cycles from mem_rd deassert until mem_dout is sampled
//   CLR_CYC    : cycles mem_rst is held for one clear
// ---------------------------------------------------------------------------
module mem_req_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYC     = 2,
  parameter int RD_LAT     = 3,
  parameter int CLR_CYC    = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_req_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 8;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_CLR     = 3'd4
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  wdata;
  } req_t;

  // FIFO storage and pointers
  req_t             fifo_q [FIFO_DEPTH];
  req_t             fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // sequencer state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr_pend_q, clr_pend_d;

  // registered outputs
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic [11:0]      rsp_addr_q, rsp_addr_d;
  logic             mem_cen_q, mem_cen_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic             mem_rst_q, mem_rst_d;
  logic [11:0]      mem_add_q, mem_add_d;
  logic [7:0]       mem_din_q, mem_din_d;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  req_t             head_s;

  // readiness reflects the occupancy before any same-cycle pop
  assign full_s  = (count_q == COUNT_MAX);
  assign empty_s = (count_q == (PTR_W + 1)'(0));
  assign push_s  = bus.req_valid && !full_s;
  assign head_s  = fifo_q[rd_ptr_q];

  assign bus.req_ready = !full_s;
  assign bus.busy      = (state_q != ST_IDLE) || !empty_s || clr_pend_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.mem_cen   = mem_cen_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_rst   = mem_rst_q;
  assign bus.mem_add   = mem_add_q;
  assign bus.mem_din   = mem_din_q;

  // Next-state logic for the sequencer, the FIFO and all registered outputs
  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_pend_d  = clr_pend_q | bus.clr_req;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    mem_cen_d   = mem_cen_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_rst_d   = mem_rst_q;
    mem_add_d   = mem_add_q;
    mem_din_d   = mem_din_q;
    pop_s       = 1'b0;

    // a consumed response drops the cycle after the handshake
    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          // a pulse arriving on the entry cycle starts a fresh pending clear
          state_d    = ST_CLR;
          clr_pend_d = bus.clr_req;
          mem_cen_d  = 1'b0;
          mem_rst_d  = 1'b1;
          cnt_d      = CNT_W'(CLR_CYC - 1);
        end else if (!empty_s && !rsp_valid_q) begin
          // an unconsumed response blocks dispatch so read data is never overrun
          pop_s     = 1'b1;
          mem_add_d = head_s.addr;
          mem_din_d = head_s.wdata;
          mem_cen_d = 1'b0;
          if (head_s.wr) begin
            state_d  = ST_WR;
            mem_wr_d = 1'b1;
            cnt_d    = CNT_W'(WR_CYC - 1);
          end else begin
            state_d  = ST_RD;
            mem_rd_d = 1'b1;
          end
        end else begin
          mem_cen_d = 1'b1;
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          mem_rst_d = 1'b0;
        end
      end

      ST_WR: begin
        if (cnt_q == CNT_ZERO) begin
          state_d   = ST_IDLE;
          mem_wr_d  = 1'b0;
          mem_cen_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_RD: begin
        state_d  = ST_RD_WAIT;
        mem_rd_d = 1'b0;
        cnt_d    = CNT_W'(RD_LAT);
      end

      ST_RD_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus.mem_dout;
          rsp_addr_d  = mem_add_q;
          mem_cen_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_CLR: begin
        if (cnt_q == CNT_ZERO) begin
          state_d   = ST_IDLE;
          mem_rst_d = 1'b0;
          mem_cen_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_cen_d = 1'b1;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        mem_rst_d = 1'b0;
      end
    endcase

    if (push_s) begin
      fifo_d[wr_ptr_q] = '{wr: bus.req_wr, addr: bus.req_addr, wdata: bus.req_wdata};
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State and output registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '{wr: 1'b0, addr: 12'h000, wdata: 8'h00};
      end
      wr_ptr_q    <= PTR_W'(0);
      rd_ptr_q    <= PTR_W'(0);
      count_q     <= (PTR_W + 1)'(0);
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      clr_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_addr_q  <= 12'h000;
      mem_cen_q   <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rst_q   <= 1'b0;
      mem_add_q   <= 12'h000;
      mem_din_q   <= 8'h00;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_pend_q  <= clr_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
      mem_cen_q   <= mem_cen_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_rst_q   <= mem_rst_d;
      mem_add_q   <= mem_add_d;
      mem_din_q   <= mem_din_d;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_req_ctrl
// Directed bench for mem_req_ctrl: a behavioural memory model answers the
// memory pins, and a linear sequence of steps checks reset values, write and
// read pin timing, bank boundary ordering, response back-pressure, clear
// sequencing, reset abandonment and simultaneous FIFO push/pop.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  logic rst;

  mem_req_ctrl_if bus_if ();

  mem_req_ctrl #(
    .FIFO_DEPTH (4),
    .WR_CYC     (2),
    .RD_LAT     (3),
    .CLR_CYC    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model state and pin observers
  logic [7:0]  mem_model [4096];
  logic [1:0]  rd_delay   = 2'd0;
  logic [11:0] rd_addr_m  = 12'h000;
  int          rd_strobes = 0;
  int          rst_cycles = 0;
  int          viol       = 0;

  // Behavioural memory: write on strobe, whole clear on mem_rst, read data
  // presented late in the latency window (0xEE before then).
  always @(posedge clk) begin
    if (!bus_if.mem_cen && bus_if.mem_wr) begin
      mem_model[bus_if.mem_add] <= bus_if.mem_din;
    end
    if (!bus_if.mem_cen && bus_if.mem_rst) begin
      for (int k = 0; k < 4096; k++) mem_model[k] <= 8'h00;
      rst_cycles <= rst_cycles + 1;
    end
    if (!bus_if.mem_cen && bus_if.mem_rd) begin
      rd_delay        <= 2'd2;
      rd_addr_m       <= bus_if.mem_add;
      bus_if.mem_dout <= 8'hEE;
      rd_strobes      <= rd_strobes + 1;
    end else if (rd_delay != 2'd0) begin
      rd_delay <= rd_delay - 2'd1;
      if (rd_delay == 2'd1) bus_if.mem_dout <= mem_model[rd_addr_m];
    end
    if ((bus_if.mem_rd && bus_if.mem_wr) ||
        (bus_if.mem_cen && (bus_if.mem_rd || bus_if.mem_wr || bus_if.mem_rst))) begin
      viol <= viol + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic wr, input logic [11:0] addr, input logic [7:0] data);
    bit done = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_wr    = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = data;
    for (int i = 0; i < 60; i++) begin
      if (bus_if.req_ready) begin
        tick();
        done = 1'b1;
        break;
      end
      tick();
    end
    bus_if.req_valid = 1'b0;
    check({tag, "_accepted"}, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (bus_if.rsp_valid) break;
      tick();
    end
    check({tag, "_rsp_valid"}, {31'd0, bus_if.rsp_valid}, 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input logic [11:0] addr, input logic [7:0] data);
    wait_valid(tag);
    check({tag, "_rdata"}, {24'd0, bus_if.rsp_rdata}, {24'd0, data});
    check({tag, "_raddr"}, {20'd0, bus_if.rsp_addr}, {20'd0, addr});
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    check({tag, "_rsp_cleared"}, {31'd0, bus_if.rsp_valid}, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!bus_if.busy) break;
      tick();
    end
    check({tag, "_idle"}, {31'd0, bus_if.busy}, 32'd0);
  endtask

  task automatic wait_rd(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (bus_if.mem_rd) break;
      tick();
    end
    check({tag, "_rd_strobe"}, {31'd0, bus_if.mem_rd}, 32'd1);
  endtask

  initial begin
    int seen;
    rst              = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_wr    = 1'b0;
    bus_if.req_addr  = 12'h000;
    bus_if.req_wdata = 8'h00;
    bus_if.clr_req   = 1'b0;
    bus_if.rsp_ready = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, bus_if.rsp_rdata}, 32'h00);
    check("rst_rsp_addr",  {20'd0, bus_if.rsp_addr},  32'h000);
    check("rst_busy",      {31'd0, bus_if.busy},      32'd0);
    check("rst_mem_cen",   {31'd0, bus_if.mem_cen},   32'd1);
    check("rst_mem_rd",    {31'd0, bus_if.mem_rd},    32'd0);
    check("rst_mem_wr",    {31'd0, bus_if.mem_wr},    32'd0);
    check("rst_mem_rst",   {31'd0, bus_if.mem_rst},   32'd0);
    check("rst_mem_add",   {20'd0, bus_if.mem_add},   32'h000);
    check("rst_mem_din",   {24'd0, bus_if.mem_din},   32'h00);
    rst = 1'b1;
    tick();

    // 1: write 0x7FF=0xA5 then read it back with exact pin timing
    push("t1_w", 1'b1, 12'h7FF, 8'hA5);
    push("t1_r", 1'b0, 12'h7FF, 8'h00);
    check("t1_wr_c1",  {31'd0, bus_if.mem_wr},  32'd1);
    check("t1_cen_c1", {31'd0, bus_if.mem_cen}, 32'd0);
    check("t1_add",    {20'd0, bus_if.mem_add}, 32'h7FF);
    check("t1_din",    {24'd0, bus_if.mem_din}, 32'hA5);
    tick();
    check("t1_wr_c2",  {31'd0, bus_if.mem_wr},  32'd1);
    tick();
    check("t1_wr_end", {31'd0, bus_if.mem_wr},  32'd0);
    check("t1_cen_idle", {31'd0, bus_if.mem_cen}, 32'd1);
    tick();
    check("t1_rd",     {31'd0, bus_if.mem_rd},  32'd1);
    check("t1_rd_add", {20'd0, bus_if.mem_add}, 32'h7FF);
    tick();
    check("t1_rd_1cyc", {31'd0, bus_if.mem_rd}, 32'd0);
    tick();
    tick();
    check("t1_rsp_early", {31'd0, bus_if.rsp_valid}, 32'd0);
    tick();
    check("t1_rsp_on_time", {31'd0, bus_if.rsp_valid}, 32'd1);
    wait_rsp("t1", 12'h7FF, 8'hA5);
    wait_idle("t1");

    // 2: bank boundary, responses in FIFO order
    push("t2_w0", 1'b1, 12'h3FF, 8'h11);
    push("t2_w1", 1'b1, 12'h400, 8'h22);
    push("t2_r0", 1'b0, 12'h3FF, 8'h00);
    push("t2_r1", 1'b0, 12'h400, 8'h00);
    wait_rsp("t2_a", 12'h3FF, 8'h11);
    wait_rsp("t2_b", 12'h400, 8'h22);
    wait_idle("t2");

    // 3: response back-pressure with five queued reads
    push("t3_r0", 1'b0, 12'h7FF, 8'h00);
    push("t3_r1", 1'b0, 12'h3FF, 8'h00);
    push("t3_r2", 1'b0, 12'h400, 8'h00);
    push("t3_r3", 1'b0, 12'h7FF, 8'h00);
    push("t3_r4", 1'b0, 12'h3FF, 8'h00);
    check("t3_full", {31'd0, bus_if.req_ready}, 32'd0);
    wait_valid("t3_first");
    repeat (8) tick();
    check("t3_hold_valid", {31'd0, bus_if.rsp_valid}, 32'd1);
    check("t3_hold_data",  {24'd0, bus_if.rsp_rdata}, 32'hA5);
    check("t3_hold_addr",  {20'd0, bus_if.rsp_addr},  32'h7FF);
    check("t3_no_extra_rd", rd_strobes, 32'd4);
    check("t3_still_full", {31'd0, bus_if.req_ready}, 32'd0);
    wait_rsp("t3_a", 12'h7FF, 8'hA5);
    wait_rsp("t3_b", 12'h3FF, 8'h11);
    wait_rsp("t3_c", 12'h400, 8'h22);
    wait_rsp("t3_d", 12'h7FF, 8'hA5);
    wait_rsp("t3_e", 12'h3FF, 8'h11);
    wait_idle("t3");
    check("t3_rd_total", rd_strobes, 32'd8);

    // 4: two clear pulses during RD_WAIT merge into one clear after the read
    push("t4_w", 1'b1, 12'h123, 8'h5A);
    wait_idle("t4_w");
    push("t4_r", 1'b0, 12'h123, 8'h00);
    wait_rd("t4");
    tick();
    bus_if.clr_req = 1'b1;
    tick();
    bus_if.clr_req = 1'b0;
    tick();
    bus_if.clr_req = 1'b1;
    tick();
    bus_if.clr_req = 1'b0;
    check("t4_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd1);
    check("t4_rsp_data",  {24'd0, bus_if.rsp_rdata}, 32'h5A);
    check("t4_rst_not_yet", {31'd0, bus_if.mem_rst}, 32'd0);
    tick();
    check("t4_rst_c1", {31'd0, bus_if.mem_rst}, 32'd1);
    check("t4_cen_c1", {31'd0, bus_if.mem_cen}, 32'd0);
    tick();
    check("t4_rst_c2", {31'd0, bus_if.mem_rst}, 32'd1);
    tick();
    check("t4_rst_end", {31'd0, bus_if.mem_rst}, 32'd0);
    check("t4_cen_end", {31'd0, bus_if.mem_cen}, 32'd1);
    repeat (4) tick();
    check("t4_single_clear", rst_cycles, 32'd2);
    wait_rsp("t4_pre", 12'h123, 8'h5A);
    push("t4_r2", 1'b0, 12'h123, 8'h00);
    wait_rsp("t4_post", 12'h123, 8'h00);
    wait_idle("t4");

    // 5: reset in the middle of RD_WAIT abandons the read
    push("t5_r", 1'b0, 12'h7FF, 8'h00);
    wait_rd("t5");
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t5_cen",       {31'd0, bus_if.mem_cen},   32'd1);
    check("t5_rd",        {31'd0, bus_if.mem_rd},    32'd0);
    check("t5_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
    check("t5_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("t5_busy",      {31'd0, bus_if.busy},      32'd0);
    tick();
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus_if.rsp_valid) seen++;
    end
    check("t5_no_response", seen, 32'd0);

    // 6: simultaneous push and pop at occupancy 3
    push("t6_w0", 1'b1, 12'h010, 8'h3C);
    push("t6_w1", 1'b1, 12'h020, 8'hC3);
    push("t6_w2", 1'b1, 12'h030, 8'h96);
    push("t6_w3", 1'b1, 12'h040, 8'h69);
    push("t6_w4", 1'b1, 12'h050, 8'h0F);
    wait_idle("t6_w");
    push("t6_r0", 1'b0, 12'h010, 8'h00);
    wait_valid("t6_r0");
    push("t6_r1", 1'b0, 12'h020, 8'h00);
    push("t6_r2", 1'b0, 12'h030, 8'h00);
    push("t6_r3", 1'b0, 12'h040, 8'h00);
    check("t6_depth3_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("t6_r0_data", {24'd0, bus_if.rsp_rdata}, 32'h3C);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_wr    = 1'b0;
    bus_if.req_addr  = 12'h050;
    tick();
    check("t6_pop_rd",    {31'd0, bus_if.mem_rd},    32'd1);
    check("t6_pop_add",   {20'd0, bus_if.mem_add},   32'h020);
    check("t6_ready_kept", {31'd0, bus_if.req_ready}, 32'd1);
    bus_if.req_addr = 12'h010;
    tick();
    bus_if.req_valid = 1'b0;
    check("t6_now_full", {31'd0, bus_if.req_ready}, 32'd0);
    wait_rsp("t6_a", 12'h020, 8'hC3);
    wait_rsp("t6_b", 12'h030, 8'h96);
    wait_rsp("t6_c", 12'h040, 8'h69);
    wait_rsp("t6_d", 12'h050, 8'h0F);
    wait_rsp("t6_e", 12'h010, 8'h3C);
    wait_idle("t6");

    check("pin_invariants", viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
